mips_id_stage: RTL and testbench
================================

Name:
mips_id_stage

Overview:
Instruction-decode stage of the 64-bit MIPS pipeline. It decodes a reduced instruction subset, reads a 32x64 register file, and forwards the write-back result into the operands. It also computes branch and jump targets and latches everything into the ID/EX pipeline register. Stall and flush insert a bubble.

Parameters:
none (datapath fixed at 64 bits, instruction 32 bits)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
fetch_pc  in  64  PC of instruction in ID
fetch_pc4  in  64  fetch_pc+4
inst  in  32  instruction word
stall  in  1  load-use hazard: insert bubble
flush  in  1  squash: insert bubble
wb_en  in  1  write-back enable
wb_regnum  in  5  write-back register
wb_data  in  64  write-back data
B_is_reg  out  1  combinational; rt is a source operand
id_write_enable  out  1  registered
id_W_regnum  out  5  registered destination
id_A_data, id_B_data  out  64  registered operands
id_pc4, id_pc_branch, id_jump_addr, id_pc  out  64  registered addresses
id_inst  out  32  registered instruction
id_load, id_store, id_beq, id_bne, id_bc, id_bal, id_syscall, id_reserved  out  1  registered flags

Behaviour:
- Decode is combinational. Fields: rs=inst[25:21], rt=inst[20:16], rd=inst[15:11], op=inst[31:26], funct=inst[5:0].
- op 0x00, funct 0x21/0x23/0x24/0x25/0x2D: write=1, dest=rd, B_is_reg=1.
- op 0x00, funct 0x0C (SYSCALL): syscall=1, write=0.
- op 0x09 ADDIU: write=1, dest=rt, B_is_reg=0.
- op 0x23 LW: load=1, write=1, dest=rt.
- op 0x2B SW: store=1, B_is_reg=1, write=0.
- op 0x04 BEQ / 0x05 BNE: beq/bne=1, B_is_reg=1, write=0. Branch source = 0.
- op 0x03 JAL: write=1, dest=31.
- op 0x32 BC: bc=1. Branch source = 1.
- op 0x3A BALC: bc=1, bal=1, write=1, dest=31. Branch source = 1.
- op 0x3B with inst[20:19]=00 (ADDIUPC): write=1, dest=rs. Branch source = 2.
- Anything else: reserved=1, write=0. All unlisted flags are 0 and the branch source is 0.
- Register file: 32x64, combinational read of rs and rt. Written at posedge when wb_en=1. Register 0 always reads 0 and ignores writes. No internal bypass. Async reset clears all registers.
- Forward A: A = wb_data if wb_en and wb_regnum==rs and rs!=0; otherwise the regfile value.
- Forward B: same rule on rt, additionally gated by B_is_reg.
- B override: if syscall or reserved, B = {32'b0, inst}.
- Branch target mux (3:1), 64-bit wrap-around adds:
  - 0: fetch_pc4 + sext(inst[15:0])<<2
  - 1: fetch_pc4 + sext(inst[25:0])<<2
  - 2: fetch_pc + sext(inst[18:0])<<2
- Jump address = {fetch_pc[63:28], inst[25:0], 2'b00}.
- Pipeline register, posedge clock:
  - reset, flush or stall: all id_* outputs become 0 (bubble), except id_pc.
  - Otherwise every output loads its decoded or computed value.
  - id_pc loads fetch_pc on every clock, even during stall or flush; it is 0 only while reset is asserted.
- Reset asserted mid-operation clears the outputs and the register file immediately (asynchronously).
- Latency: 1 cycle from inst to id_* outputs. Write-back is visible to the same-cycle decode via forwarding.

Test Plan:
- Reset, then ADDU (0x00221821) with r1=5, r2=7 preloaded via wb -> id_A_data=5, id_B_data=7, id_W_regnum=3, id_write_enable=1.
- Same-cycle wb_en=1, wb_regnum=1, wb_data=0xAA while decoding ADDIU with rs=1 -> id_A_data=0xAA. Repeat with wb_regnum=0 -> no forwarding, id_A_data=0.
- BEQ with imm16=0xFFFF at fetch_pc=0x1000 -> id_pc_branch=0x1000. BALC with offset 4 -> id_pc_branch=0x1014, id_W_regnum=31.
- ADDIUPC (op 0x3B) with imm19=1 at fetch_pc=0x2000 -> id_pc_branch=0x2004, id_W_regnum=rs.
- Opcode 0x3F -> id_reserved=1, id_B_data={32'b0,inst}, id_write_enable=0. SYSCALL -> id_syscall=1.
- stall=1 or flush=1 on a valid ADDU -> all id_* outputs 0 while id_pc=fetch_pc. Async reset mid-stream -> outputs and registers 0 without a clock edge.

Source files
------------

// File: rtl/mips_id_stage.sv
// mips_id_stage: instruction-decode stage of the 64-bit MIPS pipeline.
//
// Decodes a reduced instruction subset and reads two operands from a 32x64
// register file. The write-back result is forwarded into those operands. The
// stage also computes the branch and jump targets and registers everything
// into the ID/EX pipeline register. Stall or flush loads a bubble.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   fetch_pc, fetch_pc4   PC of the instruction in ID, and PC+4
//   inst                  instruction word being decoded
//   stall, flush          either one loads a bubble into the ID/EX register
//   wb_en/regnum/data     register-file write port from write-back
//   B_is_reg              combinational: rt is a source operand
//   id_*                  registered ID/EX outputs (id_pc is never bubbled)
module mips_id_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] fetch_pc,
    input  logic [63:0] fetch_pc4,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_regnum,
    input  logic [63:0] wb_data,
    output logic        B_is_reg,
    output logic        id_write_enable,
    output logic [4:0]  id_W_regnum,
    output logic [63:0] id_A_data,
    output logic [63:0] id_B_data,
    output logic [63:0] id_pc4,
    output logic [63:0] id_pc_branch,
    output logic [63:0] id_jump_addr,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_load,
    output logic        id_store,
    output logic        id_beq,
    output logic        id_bne,
    output logic        id_bc,
    output logic        id_bal,
    output logic        id_syscall,
    output logic        id_reserved
);

    typedef enum logic [1:0] {
        BR_PC4_IMM16 = 2'd0,  // conditional branches
        BR_PC4_IMM26 = 2'd1,  // BC / BALC
        BR_PC_IMM19  = 2'd2   // ADDIUPC, relative to the instruction's own PC
    } br_src_t;

    typedef struct packed {
        logic       write;
        logic [4:0] dest;
        logic       b_is_reg;
        logic       load;
        logic       store;
        logic       beq;
        logic       bne;
        logic       bc;
        logic       bal;
        logic       syscall;
        logic       reserved;
        br_src_t    br_src;
    } decode_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op    = inst[31:26];
    assign funct = inst[5:0];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];

    decode_t dec;

    always_comb begin
        // NOTE: every field gets a default first so no path leaves one unassigned (no latches).
        dec          = '0;
        dec.reserved = 1'b1;
        dec.br_src   = BR_PC4_IMM16;
        unique case (op)
            6'h00: begin
                if (funct == 6'h21 || funct == 6'h23 || funct == 6'h24 ||
                    funct == 6'h25 || funct == 6'h2D) begin
                    dec.write    = 1'b1;
                    dec.dest     = rd;
                    dec.b_is_reg = 1'b1;
                    dec.reserved = 1'b0;
                end else if (funct == 6'h0C) begin
                    dec.syscall  = 1'b1;
                    dec.reserved = 1'b0;
                end
            end
            6'h09: begin
                dec.write    = 1'b1;
                dec.dest     = rt;
                dec.reserved = 1'b0;
            end
            6'h23: begin
                dec.load     = 1'b1;
                dec.write    = 1'b1;
                dec.dest     = rt;
                dec.reserved = 1'b0;
            end
            6'h2B: begin
                dec.store    = 1'b1;
                dec.b_is_reg = 1'b1;
                dec.reserved = 1'b0;
            end
            6'h04: begin
                dec.beq      = 1'b1;
                dec.b_is_reg = 1'b1;
                dec.reserved = 1'b0;
            end
            6'h05: begin
                dec.bne      = 1'b1;
                dec.b_is_reg = 1'b1;
                dec.reserved = 1'b0;
            end
            6'h03: begin
                dec.write    = 1'b1;
                dec.dest     = 5'd31;
                dec.reserved = 1'b0;
            end
            6'h32: begin
                dec.bc       = 1'b1;
                dec.br_src   = BR_PC4_IMM26;
                dec.reserved = 1'b0;
            end
            6'h3A: begin
                dec.bc       = 1'b1;
                dec.bal      = 1'b1;
                dec.write    = 1'b1;
                dec.dest     = 5'd31;
                dec.br_src   = BR_PC4_IMM26;
                dec.reserved = 1'b0;
            end
            6'h3B: begin
                // Only the ADDIUPC sub-encoding is implemented; the rest stay reserved.
                if (inst[20:19] == 2'b00) begin
                    dec.write    = 1'b1;
                    dec.dest     = rs;
                    dec.br_src   = BR_PC_IMM19;
                    dec.reserved = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign B_is_reg = dec.b_is_reg;

    // Register file: combinational read, write at posedge, no internal bypass.
    logic [63:0] rf [32];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: this array is cleared on reset on purpose; the pipeline relies on all-zero registers after reset.
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_en && wb_regnum != 5'd0) begin
            // NOTE: non-blocking assignment for all clocked state.
            rf[wb_regnum] <= wb_data;
        end
    end

    logic [63:0] a_data;
    logic [63:0] b_data;
    logic [63:0] pc_branch;
    logic [63:0] jump_addr;

    always_comb begin
        a_data = (wb_en && wb_regnum == rs && rs != 5'd0) ? wb_data : rf[rs];
        b_data = (dec.b_is_reg && wb_en && wb_regnum == rt && rt != 5'd0) ? wb_data : rf[rt];
        // Trap-style instructions carry the raw instruction word to EX as B.
        if (dec.syscall || dec.reserved) b_data = {32'b0, inst};
    end

    always_comb begin
        unique case (dec.br_src)
            BR_PC4_IMM26: pc_branch = fetch_pc4 + {{36{inst[25]}}, inst[25:0], 2'b00};
            BR_PC_IMM19:  pc_branch = fetch_pc  + {{43{inst[18]}}, inst[18:0], 2'b00};
            default:      pc_branch = fetch_pc4 + {{46{inst[15]}}, inst[15:0], 2'b00};
        endcase
    end

    assign jump_addr = {fetch_pc[63:28], inst[25:0], 2'b00};

    // ID/EX register. id_pc tracks fetch_pc even across bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_pc           <= '0;
            id_write_enable <= 1'b0;
            id_W_regnum     <= '0;
            id_A_data       <= '0;
            id_B_data       <= '0;
            id_pc4          <= '0;
            id_pc_branch    <= '0;
            id_jump_addr    <= '0;
            id_inst         <= '0;
            {id_load, id_store, id_beq, id_bne, id_bc, id_bal, id_syscall, id_reserved} <= '0;
        end else begin
            id_pc <= fetch_pc;
            if (stall || flush) begin
                id_write_enable <= 1'b0;
                id_W_regnum     <= '0;
                id_A_data       <= '0;
                id_B_data       <= '0;
                id_pc4          <= '0;
                id_pc_branch    <= '0;
                id_jump_addr    <= '0;
                id_inst         <= '0;
                {id_load, id_store, id_beq, id_bne, id_bc, id_bal, id_syscall, id_reserved} <= '0;
            end else begin
                id_write_enable <= dec.write;
                id_W_regnum     <= dec.dest;
                id_A_data       <= a_data;
                id_B_data       <= b_data;
                id_pc4          <= fetch_pc4;
                id_pc_branch    <= pc_branch;
                id_jump_addr    <= jump_addr;
                id_inst         <= inst;
                {id_load, id_store, id_beq, id_bne, id_bc, id_bal, id_syscall, id_reserved} <=
                    {dec.load, dec.store, dec.beq, dec.bne, dec.bc, dec.bal, dec.syscall, dec.reserved};
            end
        end
    end

endmodule

// File: tb/tb_mips_id_stage.sv
// tb_mips_id_stage: self-checking bench for mips_id_stage.
// Directed table of hand-derived vectors, hand-written stall/flush/reset
// sequences, then randomized instructions checked against a reference model.
module tb_mips_id_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] fetch_pc, fetch_pc4;
    logic [31:0] inst;
    logic        stall, flush, wb_en;
    logic [4:0]  wb_regnum;
    logic [63:0] wb_data;
    logic        B_is_reg, id_write_enable;
    logic [4:0]  id_W_regnum;
    logic [63:0] id_A_data, id_B_data, id_pc4, id_pc_branch, id_jump_addr, id_pc;
    logic [31:0] id_inst;
    logic        id_load, id_store, id_beq, id_bne, id_bc, id_bal, id_syscall, id_reserved;

    mips_id_stage dut (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .fetch_pc4(fetch_pc4),
        .inst(inst), .stall(stall), .flush(flush), .wb_en(wb_en),
        .wb_regnum(wb_regnum), .wb_data(wb_data), .B_is_reg(B_is_reg),
        .id_write_enable(id_write_enable), .id_W_regnum(id_W_regnum),
        .id_A_data(id_A_data), .id_B_data(id_B_data), .id_pc4(id_pc4),
        .id_pc_branch(id_pc_branch), .id_jump_addr(id_jump_addr), .id_pc(id_pc),
        .id_inst(id_inst), .id_load(id_load), .id_store(id_store), .id_beq(id_beq),
        .id_bne(id_bne), .id_bc(id_bc), .id_bal(id_bal), .id_syscall(id_syscall),
        .id_reserved(id_reserved)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        stall;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_regnum;
        logic [63:0] wb_data;
    } stim_t;

    typedef struct packed {
        logic        breg;
        logic        we;
        logic [4:0]  w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] pc4;
        logic [63:0] br;
        logic [63:0] jump;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [7:0]  flags;  // load,store,beq,bne,bc,bal,syscall,reserved
    } exp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wb_en;
        logic [4:0]  wb_regnum;
        logic [63:0] wb_data;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] br;
        logic [4:0]  w;
        logic        we;
        logic        breg;
        logic [7:0]  flags;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] model_rf [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] dut_flags();
        return {id_load, id_store, id_beq, id_bne, id_bc, id_bal, id_syscall, id_reserved};
    endfunction

    function automatic logic bubble_nonzero();
        return |{id_write_enable, id_W_regnum, id_A_data, id_B_data, id_pc4,
                 id_pc_branch, id_jump_addr, id_inst, dut_flags()};
    endfunction

    // Reference model: expected ID/EX contents from the instruction-set rules.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic [5:0] op    = s.inst[31:26];
        logic [5:0] funct = s.inst[5:0];
        logic [4:0] rs = s.inst[25:21], rt = s.inst[20:16], rd = s.inst[15:11];
        logic wr = 0, breg = 0, ld = 0, st = 0, bq = 0, bn = 0, bc = 0, bal = 0, sc = 0, res = 1;
        logic [4:0] dst = 0;
        int src = 0;
        longint off;
        logic [63:0] base;
        case (op)
            6'h00: if (funct inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2D}) begin
                       wr = 1; dst = rd; breg = 1; res = 0;
                   end else if (funct == 6'h0C) begin
                       sc = 1; res = 0;
                   end
            6'h09: begin wr = 1; dst = rt; res = 0; end
            6'h23: begin ld = 1; wr = 1; dst = rt; res = 0; end
            6'h2B: begin st = 1; breg = 1; res = 0; end
            6'h04: begin bq = 1; breg = 1; res = 0; end
            6'h05: begin bn = 1; breg = 1; res = 0; end
            6'h03: begin wr = 1; dst = 31; res = 0; end
            6'h32: begin bc = 1; src = 1; res = 0; end
            6'h3A: begin bc = 1; bal = 1; wr = 1; dst = 31; src = 1; res = 0; end
            6'h3B: if (s.inst[20:19] == 2'b00) begin wr = 1; dst = rs; src = 2; res = 0; end
            default: ;
        endcase
        e = '0;
        e.breg = breg;
        e.pc   = s.pc;
        if (s.stall || s.flush) return e;
        e.we  = wr;
        e.w   = dst;
        e.a   = (s.wb_en && s.wb_regnum == rs && rs != 0) ? s.wb_data : model_rf[rs];
        e.b   = (breg && s.wb_en && s.wb_regnum == rt && rt != 0) ? s.wb_data : model_rf[rt];
        if (sc || res) e.b = {32'b0, s.inst};
        e.pc4 = s.pc + 64'd4;
        case (src)
            1:       begin base = s.pc + 64'd4; off = longint'($signed(s.inst[25:0])); end
            2:       begin base = s.pc;         off = longint'($signed(s.inst[18:0])); end
            default: begin base = s.pc + 64'd4; off = longint'($signed(s.inst[15:0])); end
        endcase
        e.br    = base + 64'(off * 4);
        e.jump  = (s.pc & ~64'h0FFF_FFFF) | (64'(s.inst[25:0]) * 64'd4);
        e.inst  = s.inst;
        e.flags = {ld, st, bq, bn, bc, bal, sc, res};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        @(negedge clock);
        fetch_pc  = s.pc;
        fetch_pc4 = s.pc + 64'd4;
        inst      = s.inst;
        stall     = s.stall;
        flush     = s.flush;
        wb_en     = s.wb_en;
        wb_regnum = s.wb_regnum;
        wb_data   = s.wb_data;
        #1;
    endtask

    task automatic clock_in(input stim_t s);
        @(posedge clock);
        #1;
        if (s.wb_en && s.wb_regnum != 0) model_rf[s.wb_regnum] = s.wb_data;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".we"},    64'(id_write_enable), 64'(e.we));
        check({tag, ".W"},     64'(id_W_regnum),     64'(e.w));
        check({tag, ".A"},     id_A_data,            e.a);
        check({tag, ".B"},     id_B_data,            e.b);
        check({tag, ".pc4"},   id_pc4,               e.pc4);
        check({tag, ".br"},    id_pc_branch,         e.br);
        check({tag, ".jump"},  id_jump_addr,         e.jump);
        check({tag, ".pc"},    id_pc,                e.pc);
        check({tag, ".inst"},  64'(id_inst),         64'(e.inst));
        check({tag, ".flags"}, 64'(dut_flags()),     64'(e.flags));
    endtask

    task automatic run_model(input string tag, input stim_t s);
        exp_t e;
        apply(s);
        e = model(s);
        check({tag, ".B_is_reg"}, 64'(B_is_reg), 64'(e.breg));
        clock_in(s);
        check_all(tag, e);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        logic [5:0] ops [11] = '{6'h00, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h05,
                                 6'h03, 6'h32, 6'h3A, 6'h3B, 6'h3F};
        logic [5:0] functs [7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2D, 6'h0C, 6'h00};
        r[31:26] = ops[$urandom_range(10)];
        if ($urandom_range(7) == 0) r[31:26] = 6'($urandom);
        if (r[31:26] == 6'h00) r[5:0] = functs[$urandom_range(6)];
        if (r[31:26] == 6'h3B && $urandom_range(1) == 0) r[20:19] = 2'b00;
        return r;
    endfunction

    vec_t tbl [15];
    stim_t s;

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        reset = 1'b1; fetch_pc = '0; fetch_pc4 = 64'd4; inst = '0;
        stall = 0; flush = 0; wb_en = 0; wb_regnum = '0; wb_data = '0;
        #12;
        check("reset.bubble", 64'(bubble_nonzero()), 64'd0);
        check("reset.id_pc", id_pc, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Preload r1=5, r2=7 (instruction is a don't-care reserved word).
        s = '{pc: 64'h40, inst: 32'h0, stall: 0, flush: 0, wb_en: 1, wb_regnum: 5'd1, wb_data: 64'd5};
        apply(s); clock_in(s);
        s.wb_regnum = 5'd2; s.wb_data = 64'd7;
        apply(s); clock_in(s);

        //        pc        inst          wbe wbr  wbd       A       B              br          W  we breg flags
        tbl[0]  = '{64'h100,  32'h00221821, 0, 0,  64'h0,  64'd5,  64'd7,         64'h6188,   3, 1, 1, 8'h00};
        tbl[1]  = '{64'h200,  32'h24220010, 1, 1,  64'hAA, 64'hAA, 64'd7,         64'h244,    2, 1, 0, 8'h00};
        tbl[2]  = '{64'h300,  32'h24020010, 1, 0,  64'hBB, 64'd0,  64'd7,         64'h344,    2, 1, 0, 8'h00};
        tbl[3]  = '{64'h1000, 32'h1022FFFF, 0, 0,  64'h0,  64'hAA, 64'd7,         64'h1000,   0, 0, 1, 8'h20};
        tbl[4]  = '{64'h1000, 32'hE8000004, 0, 0,  64'h0,  64'd0,  64'd0,         64'h1014,  31, 1, 0, 8'h0C};
        tbl[5]  = '{64'h2000, 32'hEC600001, 0, 0,  64'h0,  64'd0,  64'd0,         64'h2004,   3, 1, 0, 8'h00};
        tbl[6]  = '{64'h400,  32'hFC000123, 0, 0,  64'h0,  64'd0,  64'hFC000123,  64'h890,    0, 0, 0, 8'h01};
        tbl[7]  = '{64'h500,  32'h0000000C, 0, 0,  64'h0,  64'd0,  64'h0000000C,  64'h534,    0, 0, 0, 8'h02};
        tbl[8]  = '{64'h600,  32'hCBFFFFFF, 0, 0,  64'h0,  64'd0,  64'd0,         64'h600,    0, 0, 0, 8'h08};
        tbl[9]  = '{64'h700,  32'hAC220008, 0, 0,  64'h0,  64'hAA, 64'd7,         64'h724,    0, 0, 1, 8'h40};
        tbl[10] = '{64'h800,  32'hEC680001, 0, 0,  64'h0,  64'd0,  64'hEC680001,  64'h808,    0, 0, 0, 8'h01};
        tbl[11] = '{64'h900,  32'h00221821, 1, 2,  64'h55, 64'hAA, 64'h55,        64'h6988,   3, 1, 1, 8'h00};
        tbl[12] = '{64'hA00,  32'h24220010, 1, 2,  64'h66, 64'hAA, 64'h55,        64'hA44,    2, 1, 0, 8'h00};
        tbl[13] = '{64'hB00,  32'h0C000010, 0, 0,  64'h0,  64'd0,  64'd0,         64'hB44,   31, 1, 0, 8'h00};
        tbl[14] = '{64'hC00,  32'h00411025, 0, 0,  64'h0,  64'h66, 64'hAA,        64'h4C98,   2, 1, 1, 8'h00};

        for (int i = 0; i < 15; i++) begin
            string tag = $sformatf("vec%0d", i);
            s = '{pc: tbl[i].pc, inst: tbl[i].inst, stall: 0, flush: 0,
                  wb_en: tbl[i].wb_en, wb_regnum: tbl[i].wb_regnum, wb_data: tbl[i].wb_data};
            apply(s);
            check({tag, ".B_is_reg"}, 64'(B_is_reg), 64'(tbl[i].breg));
            clock_in(s);
            check({tag, ".A"},     id_A_data,            tbl[i].a);
            check({tag, ".B"},     id_B_data,            tbl[i].b);
            check({tag, ".br"},    id_pc_branch,         tbl[i].br);
            check({tag, ".we"},    64'(id_write_enable), 64'(tbl[i].we));
            if (tbl[i].we) check({tag, ".W"}, 64'(id_W_regnum), 64'(tbl[i].w));
            check({tag, ".flags"}, 64'(dut_flags()),     64'(tbl[i].flags));
            check({tag, ".pc"},    id_pc,                tbl[i].pc);
            check({tag, ".inst"},  64'(id_inst),         64'(tbl[i].inst));
        end

        // Stall and flush on a valid ADDU: bubble everywhere, id_pc still follows fetch_pc.
        s = '{pc: 64'hD00, inst: 32'h00221821, stall: 1, flush: 0, wb_en: 0, wb_regnum: 0, wb_data: 0};
        apply(s); clock_in(s);
        check("stall.bubble", 64'(bubble_nonzero()), 64'd0);
        check("stall.id_pc", id_pc, 64'hD00);
        s.stall = 0; s.flush = 1; s.pc = 64'hE00;
        apply(s); clock_in(s);
        check("flush.bubble", 64'(bubble_nonzero()), 64'd0);
        check("flush.id_pc", id_pc, 64'hE00);

        // Valid ADDU, then reset mid-cycle: outputs clear without a clock edge.
        s.flush = 0; s.pc = 64'hF00;
        apply(s); clock_in(s);
        check("pre_reset.A", id_A_data, 64'hAA);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset.bubble", 64'(bubble_nonzero()), 64'd0);
        check("async_reset.id_pc", id_pc, 64'd0);
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        @(negedge clock);
        reset = 1'b0;
        s.pc = 64'h1F00;
        run_model("post_reset", s);
        check("post_reset.A_zero", id_A_data, 64'd0);

        // Randomized instruction stream against the reference model.
        for (int i = 0; i < 400; i++) begin
            s.pc = {$urandom, $urandom};
            if ($urandom_range(7) == 0) s.pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            s.inst      = rand_inst();
            s.stall     = ($urandom_range(9) == 0);
            s.flush     = ($urandom_range(9) == 0);
            s.wb_en     = $urandom_range(1) == 1;
            s.wb_regnum = 5'($urandom);
            s.wb_data   = {$urandom, $urandom};
            run_model($sformatf("rand%0d", i), s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
